// File: rtl/ip_uart_rx.sv
// ip_uart_rx: 8N1 UART receiver with a 2-flop input synchroniser,
// mid-bit sampling, a one-byte holding register and valid/error strobes.
module ip_uart_rx #(
    parameter int clk_freq  = 54000000,
    parameter int uart_freq = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] recv_data,
    output logic       recv_valid,
    output logic       recv_error
);

    localparam int DIV  = clk_freq / uart_freq;
    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CNT_BIT  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          error_q, error_d;
    logic          rx_meta_q, rx_sync_q;
    logic          w_rx;
    logic          tick;

    assign w_rx = rx_sync_q;
    assign tick = (count_q == '0);

    // Two-flop synchroniser for the asynchronous serial pin; idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Frame FSM state, bit timer, shifter and registered strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    // Next-state logic: sample each bit when the timer reaches zero.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!w_rx) begin
                    state_d = S_START;
                    count_d = CNT_HALF;
                end
            end
            S_START: begin
                if (tick) begin
                    if (!w_rx) begin
                        state_d = S_DATA;
                        count_d = CNT_BIT;
                        bit_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = {w_rx, shift_q[7:1]};
                    count_d = CNT_BIT;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (w_rx) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            S_BREAK: begin
                if (w_rx) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign recv_data  = data_q;
    assign recv_valid = valid_q;
    assign recv_error = error_q;

endmodule

// File: tb/tb_ip_uart_rx.sv
// tb_ip_uart_rx: directed and randomized frames against a queue-based
// model of expected bytes, error counts and pin-to-strobe latency.
module tb_ip_uart_rx;

    localparam int CLK_F = 3200000;
    localparam int BAUD  = 100000;
    localparam int DIV   = CLK_F / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int LAT   = 2 + HALF + 9 * DIV + 1;
    localparam int NRND  = 64;

    logic       clk;
    logic       reset;
    logic       uart_rx;
    logic [7:0] recv_data;
    logic       recv_valid;
    logic       recv_error;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int both_n = 0;

    logic [7:0] rx_q[$];
    int         rx_t[$];
    int         err_t[$];
    logic [7:0] exp_q[$];

    ip_uart_rx #(
        .clk_freq (CLK_F),
        .uart_freq(BAUD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .recv_data (recv_data),
        .recv_valid(recv_valid),
        .recv_error(recv_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (recv_valid) begin
                rx_q.push_back(recv_data);
                rx_t.push_back(cyc);
            end
            if (recv_error) err_t.push_back(cyc);
            if (recv_valid && recv_error) both_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        uart_rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int per, input logic stp);
        drive_bit(1'b0, per);
        for (int i = 0; i < 8; i++) drive_bit(b[i], per);
        drive_bit(stp, per);
        uart_rx = 1'b1;
    endtask

    task automatic clear_log();
        rx_q.delete();
        rx_t.delete();
        err_t.delete();
    endtask

    initial begin
        int t0;
        logic [7:0] b;

        reset   = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", recv_data, 8'h00);
        check("rst_valid", recv_valid, 1'b0);
        check("rst_error", recv_error, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        drive_bit(1'b1, 2 * DIV);

        // back-to-back frames and exact latency
        clear_log();
        t0 = cyc;
        send(8'h55, DIV, 1'b1);
        send(8'hA5, DIV, 1'b1);
        drive_bit(1'b1, 2 * DIV);
        check("b2b_count", rx_q.size(), 2);
        check("b2b_byte0", rx_q[0], 8'h55);
        check("b2b_byte1", rx_q[1], 8'hA5);
        check("b2b_lat0", rx_t[0], t0 + LAT);
        check("b2b_lat1", rx_t[1], t0 + 10 * DIV + LAT);
        check("b2b_err", err_t.size(), 0);

        // short low glitch is rejected
        clear_log();
        drive_bit(1'b0, HALF - 6);
        drive_bit(1'b1, 4 * DIV);
        check("glitch_valid", rx_q.size(), 0);
        check("glitch_err", err_t.size(), 0);
        check("glitch_data", recv_data, 8'hA5);

        // framing error on stop bit
        clear_log();
        t0 = cyc;
        send(8'h3C, DIV, 1'b0);
        drive_bit(1'b1, 2 * DIV);
        check("ferr_count", err_t.size(), 1);
        check("ferr_lat", err_t[0], t0 + LAT);
        check("ferr_valid", rx_q.size(), 0);
        check("ferr_data", recv_data, 8'hA5);

        // long break gives one error, then recovery
        clear_log();
        drive_bit(1'b0, 20 * DIV);
        drive_bit(1'b1, 2 * DIV);
        send(8'h3C, DIV, 1'b1);
        drive_bit(1'b1, 2 * DIV);
        check("brk_err", err_t.size(), 1);
        check("brk_count", rx_q.size(), 1);
        check("brk_byte", rx_q[0], 8'h3C);

        // reset in the middle of data bit 4
        clear_log();
        fork
            send(8'hFF, DIV, 1'b1);
            begin
                repeat (5 * DIV + HALF) @(posedge clk);
                #2 reset = 1'b1;
                repeat (4) @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                check("mrst_data", recv_data, 8'h00);
            end
        join
        drive_bit(1'b1, 2 * DIV);
        check("mrst_valid", rx_q.size(), 0);
        check("mrst_err", err_t.size(), 0);
        send(8'h81, DIV, 1'b1);
        drive_bit(1'b1, 2 * DIV);
        check("mrst_count", rx_q.size(), 1);
        check("mrst_byte", rx_q[0], 8'h81);

        // line low at reset release acts as a start edge
        clear_log();
        uart_rx = 1'b0;
        reset   = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        drive_bit(1'b0, 12 * DIV);
        drive_bit(1'b1, 2 * DIV);
        check("lowrel_err", err_t.size(), 1);
        check("lowrel_valid", rx_q.size(), 0);
        send(8'h5A, DIV, 1'b1);
        drive_bit(1'b1, 2 * DIV);
        check("lowrel_byte", rx_q[0], 8'h5A);

        // random bytes at about -3% and +3% baud error
        for (int p = 0; p < 2; p++) begin
            int per;
            per = (p == 0) ? DIV - 1 : DIV + 1;
            clear_log();
            exp_q.delete();
            for (int i = 0; i < NRND; i++) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                send(b, per, 1'b1);
            end
            drive_bit(1'b1, 3 * DIV);
            check("rnd_count", rx_q.size(), exp_q.size());
            check("rnd_err", err_t.size(), 0);
            for (int i = 0; i < NRND; i++) begin
                check($sformatf("rnd_p%0d_b%0d", per, i), rx_q[i], exp_q[i]);
            end
        end

        check("never_both", both_n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
